icache_fifo_reader: RTL and testbench
=====================================

// Module: icache_fifo_reader
// PURPOSE
//  Read-side drain engine for icache_fifo. Owns the FIFO's pop strobe: pops words while the FIFO is
//  non-empty and local space exists, and re-times them into a registered valid/ready stream via a
//  2-entry output buffer (head + skid). Provides a flush that discards buffered words and drains the FIFO.
// PARAMETERS
//  FIFO_WIDTH  32  data width; must match the attached icache_fifo
//  CNT_WIDTH   16  width of delivered-beat counter
// PORTS
//  clk         in   1           clock, all state on rising edge
//  rst         in   1           asynchronous reset, active-high
//  fifo_rdata  in   FIFO_WIDTH  FIFO head word (combinational read of current read pointer)
//  fifo_empty  in   1           FIFO empty flag
//  fifo_rd     out  1           FIFO pop strobe; one word consumed per cycle high
//  out_valid   out  1           out_data holds a valid word
//  out_ready   in   1           consumer accepts; beat = out_valid & out_ready
//  out_data    out  FIFO_WIDTH  head-of-buffer word (registered)
//  flush       in   1           single-cycle flush request
//  flush_busy  out  1           high while in FLUSH state
//  beat_cnt    out  CNT_WIDTH   number of delivered beats, wraps mod 2^CNT_WIDTH
// BEHAVIOUR
//  Reset (async): state=RUN, occ=0, head=skid=0, beat_cnt=0 -> out_valid=0, out_data=0, flush_busy=0;
//   fifo_rd forced 0 while rst high. Reset mid-operation loses buffered words; the FIFO resets itself.
//  State machine {RUN, FLUSH}; occupancy occ in {0,1,2}; out_valid = (occ!=0); out_data = head.
//  fifo_rd = ~rst & ~fifo_empty & (flush | state==FLUSH | (state==RUN & occ<2)).
//   fifo_rd never high when fifo_empty=1. No combinational path from out_ready to fifo_rd.
//  RUN, no flush; pop = fifo_rd, deq = out_valid & out_ready; word popped = fifo_rdata at same edge:
//   occ0: pop -> head<=fifo_rdata, occ1.
//   occ1: pop&deq -> head<=fifo_rdata, occ1; pop&~deq -> skid<=fifo_rdata, occ2; deq only -> occ0.
//   occ2: no pop possible; deq -> head<=skid, occ1.
//  Latency: word popped in cycle N is on out_data with out_valid in N+1. Sustained 1 word/cycle at occ1.
//  Ordering: strict FIFO order out; no loss, no duplication outside flush.
//  beat_cnt += 1 on every deq (including a deq in the flush cycle); wraps to 0 past all-ones.
//  flush in RUN: that cycle's deq still counts; any popped word discarded; next cycle state=FLUSH, occ=0.
//  FLUSH: fifo_rd = ~fifo_empty, popped words discarded, out_valid=0, beat_cnt frozen.
//   Exit to RUN on the edge where fifo_empty=1 is sampled in FLUSH; flush asserted in FLUSH is ignored.
//   Writer pushes during FLUSH are drained too; FLUSH lasts until FIFO seen empty.
//  flush with FIFO already empty and occ=0: one cycle of FLUSH, then RUN.
//  Width: all data paths FIFO_WIDTH, no truncation or extension.
// TESTING
//  1 FIFO holds A,B,C, out_ready=1 -> fifo_rd high 3 consecutive cycles; A,B,C on out_data in next 3
//    cycles with out_valid each; beat_cnt=3; fifo_rd low afterwards.
//  2 FIFO holds A..E, out_ready=0 -> exactly 2 pops, out_data=A held, occ=2; raise out_ready -> A,B,C,D,E
//    delivered on 5 consecutive cycles, no gaps, beat_cnt=5.
//  3 occ=2 (A,B buffered), FIFO holds C,D,E, pulse flush with out_ready=0 -> flush_busy=1, out_valid=0
//    next cycle; 3 pops; back to RUN after empty seen; beat_cnt unchanged; subsequent F delivered first.
//  4 FIFO empty for 20 cycles, random out_ready/flush -> fifo_rd never 1; out_valid never 1.
//  5 CNT_WIDTH=4, 17 beats delivered -> beat_cnt=1 (wrap).
//  6 rst pulsed mid-stall between clock edges -> out_valid, out_data, flush_busy, beat_cnt, fifo_rd all 0
//    immediately without a clock edge; after release, normal draining resumes.

Source files
------------

// File: rtl/icache_fifo_reader.sv
// Read-side drain engine for icache_fifo: pops words into a head/skid output buffer
// and presents them as a registered valid/ready stream, with a flush that drains the FIFO.
module icache_fifo_reader #(
  parameter int unsigned FIFO_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FIFO_WIDTH-1:0] out_data,
  input  logic                  flush,
  output logic                  flush_busy,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                state, state_next;
  logic [1:0]            occ, occ_next;
  logic [FIFO_WIDTH-1:0] head, head_next;
  logic [FIFO_WIDTH-1:0] skid, skid_next;
  logic [CNT_WIDTH-1:0]  cnt, cnt_next;
  logic                  deq;

  assign out_valid  = (occ != 2'd0);
  assign out_data   = head;
  assign flush_busy = (state == FLUSH);
  assign beat_cnt   = cnt;
  assign deq        = out_valid & out_ready;

  // Pop decision uses only registered occupancy, never out_ready, to keep the
  // consumer's ready off the FIFO's read timing path.
  assign fifo_rd = ~rst & ~fifo_empty &
                   (flush | (state == FLUSH) | ((state == RUN) & (occ != 2'd2)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      occ   <= 2'd0;
      head  <= '0;
      skid  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      occ   <= occ_next;
      head  <= head_next;
      skid  <= skid_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    occ_next   = occ;
    head_next  = head;
    skid_next  = skid;
    cnt_next   = deq ? cnt + CNT_WIDTH'(1) : cnt;
    case (state)
      RUN: begin
        if (flush) begin
          state_next = FLUSH;
          occ_next   = 2'd0;
        end else begin
          case (occ)
            2'd0: begin
              if (fifo_rd) begin
                head_next = fifo_rdata;
                occ_next  = 2'd1;
              end
            end
            2'd1: begin
              if (fifo_rd && deq) begin
                head_next = fifo_rdata;
              end else if (fifo_rd) begin
                skid_next = fifo_rdata;
                occ_next  = 2'd2;
              end else if (deq) begin
                occ_next  = 2'd0;
              end
            end
            2'd2: begin
              if (deq) begin
                head_next = skid;
                occ_next  = 2'd1;
              end
            end
            default: occ_next = 2'd0;
          endcase
        end
      end
      FLUSH: begin
        if (fifo_empty) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

endmodule

// File: tb/tb_icache_fifo_reader.sv
// Directed bench for icache_fifo_reader with a small behavioural FIFO feeding the DUT.
module tb_icache_fifo_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fifo_rdata;
  logic        fifo_empty;
  logic        fifo_rd;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        flush = 1'b0;
  logic        flush_busy;
  logic [15:0] beat_cnt;

  // second instance with narrow counter for the wrap check
  logic        en2 = 1'b0;
  logic        fifo_rd2, out_valid2, flush_busy2;
  logic [31:0] out_data2;
  logic [3:0]  beat_cnt2;

  logic [31:0] mem [0:15];
  logic [7:0]  rp = 8'd0;
  logic [7:0]  wp = 8'd0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (rp == wp);
  assign fifo_rdata = mem[rp[3:0]];

  // the FIFO resets itself alongside the reader
  always @(posedge clk or posedge rst) begin
    if (rst) rp <= wp;
    else if (fifo_rd) rp <= rp + 8'd1;
  end

  icache_fifo_reader #(.FIFO_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush(flush), .flush_busy(flush_busy), .beat_cnt(beat_cnt)
  );

  icache_fifo_reader #(.FIFO_WIDTH(32), .CNT_WIDTH(4)) dut2 (
    .clk(clk), .rst(rst), .fifo_rdata(32'h0000_5a5a), .fifo_empty(~en2),
    .fifo_rd(fifo_rd2), .out_valid(out_valid2), .out_ready(1'b1),
    .out_data(out_data2), .flush(1'b0), .flush_busy(flush_busy2), .beat_cnt(beat_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    mem[wp[3:0]] = d;
    wp = wp + 8'd1;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_busy", {31'd0, flush_busy}, 32'd0);
    chk("rst_cnt", {16'd0, beat_cnt}, 32'd0);
    chk("rst_rd", {31'd0, fifo_rd}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // 1: A,B,C with out_ready=1
    out_ready = 1'b1;
    push(32'hA); push(32'hB); push(32'hC);
    #1;
    chk("t1_rd0", {31'd0, fifo_rd}, 32'd1);
    step();
    chk("t1_dA", out_data, 32'hA);
    chk("t1_vA", {31'd0, out_valid}, 32'd1);
    chk("t1_rd1", {31'd0, fifo_rd}, 32'd1);
    step();
    chk("t1_dB", out_data, 32'hB);
    chk("t1_rd2", {31'd0, fifo_rd}, 32'd1);
    step();
    chk("t1_dC", out_data, 32'hC);
    chk("t1_vC", {31'd0, out_valid}, 32'd1);
    chk("t1_rd3", {31'd0, fifo_rd}, 32'd0);
    step();
    chk("t1_v_end", {31'd0, out_valid}, 32'd0);
    chk("t1_cnt", {16'd0, beat_cnt}, 32'd3);
    chk("t1_rd_end", {31'd0, fifo_rd}, 32'd0);

    // 2: A..E stalled, then drained back to back
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 5; i++) push(32'h10 + i);
    #1;
    step();
    step();
    step();
    step();
    chk("t2_rd_stall", {31'd0, fifo_rd}, 32'd0);
    chk("t2_pops", {24'd0, wp - rp}, 32'd3);
    chk("t2_hold", out_data, 32'h10);
    chk("t2_vhold", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    for (int unsigned i = 1; i < 5; i++) begin
      step();
      chk("t2_data", out_data, 32'h10 + i);
      chk("t2_valid", {31'd0, out_valid}, 32'd1);
    end
    step();
    chk("t2_v_end", {31'd0, out_valid}, 32'd0);
    chk("t2_cnt", {16'd0, beat_cnt}, 32'd8);

    // 3: flush with two buffered words and three in the FIFO
    out_ready = 1'b0;
    push(32'h20); push(32'h21);
    #1;
    step();
    step();
    push(32'h22); push(32'h23); push(32'h24);
    #1;
    chk("t3_rd_full", {31'd0, fifo_rd}, 32'd0);
    flush = 1'b1;
    #1;
    chk("t3_rd_flush", {31'd0, fifo_rd}, 32'd1);
    step();
    flush = 1'b1;  // ignored while already flushing
    #1;
    chk("t3_busy1", {31'd0, flush_busy}, 32'd1);
    chk("t3_v1", {31'd0, out_valid}, 32'd0);
    chk("t3_rd1", {31'd0, fifo_rd}, 32'd1);
    step();
    flush = 1'b0;
    #1;
    chk("t3_busy2", {31'd0, flush_busy}, 32'd1);
    step();
    chk("t3_busy3", {31'd0, flush_busy}, 32'd1);
    chk("t3_rd3", {31'd0, fifo_rd}, 32'd0);
    step();
    chk("t3_busy4", {31'd0, flush_busy}, 32'd0);
    chk("t3_drained", {24'd0, wp - rp}, 32'd0);
    chk("t3_cnt", {16'd0, beat_cnt}, 32'd8);
    out_ready = 1'b1;
    push(32'h30);
    #1;
    step();
    chk("t3_dF", out_data, 32'h30);
    chk("t3_vF", {31'd0, out_valid}, 32'd1);
    step();
    chk("t3_cnt2", {16'd0, beat_cnt}, 32'd9);

    // 4: empty FIFO, flush and random controls
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("t4_busy", {31'd0, flush_busy}, 32'd1);
    step();
    chk("t4_busy_off", {31'd0, flush_busy}, 32'd0);
    for (int unsigned i = 0; i < 20; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      flush     = 1'($urandom_range(0, 1));
      #1;
      chk("t4_rd", {31'd0, fifo_rd}, 32'd0);
      chk("t4_valid", {31'd0, out_valid}, 32'd0);
      step();
    end
    flush = 1'b0;
    step();
    step();
    chk("t4_cnt", {16'd0, beat_cnt}, 32'd9);

    // 5: 4-bit counter wrap after 17 beats
    en2 = 1'b1;
    for (int unsigned i = 0; i < 16; i++) step();
    chk("t5_cnt15", {28'd0, beat_cnt2}, 32'd15);
    step();
    en2 = 1'b0;
    step();
    step();
    chk("t5_wrap", {28'd0, beat_cnt2}, 32'd1);

    // 6: async reset mid-stall
    out_ready = 1'b0;
    push(32'h40); push(32'h41); push(32'h42);
    #1;
    step();
    step();
    chk("t6_pre_v", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_v", {31'd0, out_valid}, 32'd0);
    chk("t6_data", out_data, 32'd0);
    chk("t6_busy", {31'd0, flush_busy}, 32'd0);
    chk("t6_cnt", {16'd0, beat_cnt}, 32'd0);
    chk("t6_rd", {31'd0, fifo_rd}, 32'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    push(32'h50); push(32'h51);
    #1;
    step();
    chk("t6_dJ", out_data, 32'h50);
    step();
    chk("t6_dK", out_data, 32'h51);
    step();
    chk("t6_v_end", {31'd0, out_valid}, 32'd0);
    chk("t6_cnt2", {16'd0, beat_cnt}, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
